// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked add/subtract with valid/ready handshakes
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [KW-1:0]    k_q;

  logic [31:0]      off;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic [WIDTH-1:0] sum_next;
  logic             last;

  // One CHUNK-bit ripple slice, steered to slice k by shifting rather than a variable part-select
  always_comb begin
    off      = 32'(k_q) * 32'(CHUNK);
    a_shift  = a_q >> off;
    b_shift  = b_q >> off;
    {c_chunk, s_chunk} = {1'b0, a_shift[CHUNK-1:0]} + {1'b0, b_shift[CHUNK-1:0]}
                         + (CHUNK+1)'(carry_q);
    sum_next = (sum & ~(CHUNK_MASK << off)) | (WIDTH'(s_chunk) << off);
    last     = (k_q == KW'(N - 1));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            k_q     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= sum_next;
          carry_q <= c_chunk;
          k_q     <= k_q + KW'(1);
          if (last) begin
            cout     <= c_chunk;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed bench for seq_chunk_adder at 16/4 and 64/8
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 0, ir16, sub16 = 0, cin16 = 0, ov16, or16 = 1;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        co16, of16;

  logic        iv64 = 0, ir64, sub64 = 0, cin64 = 0, ov64, or64 = 1;
  logic [63:0] a64 = 0, b64 = 0, s64;
  logic        co64, of64;

  int passed = 0;
  int total  = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .overflow(of16)
  );

  seq_chunk_adder dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64),
    .sum(s64), .cout(co64), .overflow(of64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Accept, check out_valid timing (low at N-1, high at N), then result, then drain
  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic c, input logic s, input logic [15:0] es,
                      input logic ec, input logic eo);
    a16 = av; b16 = bv; cin16 = c; sub16 = s; iv16 = 1;
    tick();
    iv16 = 0; a16 = 16'hA5A5; b16 = 16'h5A5A; cin16 = ~c; sub16 = ~s;
    repeat (3) tick();
    chk({tag, ".ov_early"}, 64'(ov16), 64'd0);
    tick();
    chk({tag, ".ov"}, 64'(ov16), 64'd1);
    chk({tag, ".sum"}, 64'(s16), 64'(es));
    chk({tag, ".cout"}, 64'(co16), 64'(ec));
    chk({tag, ".ovf"}, 64'(of16), 64'(eo));
    tick();
  endtask

  task automatic op64(input string tag, input logic [63:0] av, input logic [63:0] bv,
                      input logic c, input logic [63:0] es, input logic ec, input logic eo);
    a64 = av; b64 = bv; cin64 = c; sub64 = 0; iv64 = 1;
    tick();
    iv64 = 0; a64 = '1; b64 = '1;
    repeat (7) tick();
    chk({tag, ".ov_early"}, 64'(ov64), 64'd0);
    tick();
    chk({tag, ".ov"}, 64'(ov64), 64'd1);
    chk({tag, ".sum"}, s64, es);
    chk({tag, ".cout"}, 64'(co64), 64'(ec));
    chk({tag, ".ovf"}, 64'(of64), 64'(eo));
    tick();
  endtask

  initial begin
    #2;
    chk("rst.in_ready", 64'(ir16), 64'd1);
    chk("rst.out_valid", 64'(ov16), 64'd0);
    chk("rst.sum", 64'(s16), 64'd0);
    chk("rst.cout_ovf", {62'd0, co16, of16}, 64'd0);
    chk("rst.sum64", s64, 64'd0);
    tick();
    rst = 0;
    tick();

    op16("add",      16'h1EFA, 16'h3FFC, 1'b1, 1'b0, 16'h5EF7, 1'b0, 1'b0);
    op16("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op16("sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("sub_nobr", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    op16("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    op64("w64_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    op64("w64_zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);

    // Backpressure with a pending new operand held on the input
    or16 = 0;
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 0; sub16 = 0; iv16 = 1;
    tick();
    a16 = 16'h0100; b16 = 16'h0020;
    repeat (4) tick();
    chk("bp.first", 64'(ov16), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp.hold%0d", i), {44'd0, ir16, ov16, s16, co16, of16},
          {44'd0, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0});
    end
    or16 = 1;
    tick();
    chk("bp.release", {62'd0, ir16, ov16}, {62'd0, 1'b1, 1'b0});
    chk("bp.keep_sum", 64'(s16), 64'h2345);
    tick();
    chk("bp.accept", 64'(ir16), 64'd0);
    iv16 = 0;
    repeat (4) tick();
    chk("bp.second", {47'd0, ov16, s16}, {47'd0, 1'b1, 16'h0120});
    tick();

    // Asynchronous reset after the second chunk
    a16 = 16'h1EFA; b16 = 16'h3FFC; cin16 = 1; sub16 = 0; iv16 = 1;
    tick();
    iv16 = 0;
    repeat (2) tick();
    #2 rst = 1;
    #1;
    chk("arst.in_ready", 64'(ir16), 64'd1);
    chk("arst.out_valid", 64'(ov16), 64'd0);
    chk("arst.sum", 64'(s16), 64'd0);
    tick();
    rst = 0;
    tick();
    op16("after_rst", 16'h1EFA, 16'h3FFC, 1'b1, 1'b0, 16'h5EF7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
